// File: rtl/ex_mul_ctrl_pkg.sv
// ex_mul_ctrl_pkg: opcode and FSM encodings shared by the EX-stage multiplier
package ex_mul_ctrl_pkg;
   localparam logic [1:0] MUL_OP_LO      = 2'b00;
   localparam logic [1:0] MUL_OP_UHI     = 2'b01;
   localparam logic [1:0] MUL_OP_SHI     = 2'b10;
   localparam logic [1:0] MUL_STATE_IDLE = 2'd0;
   localparam logic [1:0] MUL_STATE_BUSY = 2'd1;
   localparam logic [1:0] MUL_STATE_DONE = 2'd2;
   // The unused encoding 11 is treated as a plain low-half multiply
   function automatic logic [1:0] mul_op_norm(input logic [1:0] op);
      return op == 2'b11 ? MUL_OP_LO : op;
   endfunction
endpackage

// File: rtl/ex_mul_dp.sv
// ex_mul_dp: shift-add product register, operand latches and signed-high correction
module ex_mul_dp
   import ex_mul_ctrl_pkg::*;
#(
   parameter int WORD = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic            capture,
   input  logic [1:0]      op,
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   output logic [WORD-1:0] result
);
   logic [2*WORD-1:0] p, p_next;
   logic [WORD:0]     sum;
   logic [WORD-1:0]   ma, mb, hi_s;
   logic [1:0]        mop;
   logic              sa, sb;
   // Unsigned product high half minus the two's-complement sign terms gives the signed high half
   always_comb begin
      sum    = {1'b0, p[2*WORD-1:WORD]} + {1'b0, p[0] ? ma : {WORD{1'b0}}};
      p_next = {sum, p[WORD-1:1]};
      hi_s   = p_next[2*WORD-1:WORD] - (sa ? mb : {WORD{1'b0}}) - (sb ? ma : {WORD{1'b0}});
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         p      <= '0;
         ma     <= '0;
         mb     <= '0;
         mop    <= MUL_OP_LO;
         sa     <= 1'b0;
         sb     <= 1'b0;
         result <= '0;
      end else begin
         if (load) begin
            p   <= {{WORD{1'b0}}, b};
            ma  <= a;
            mb  <= b;
            mop <= mul_op_norm(op);
            sa  <= a[WORD-1];
            sb  <= b[WORD-1];
         end else if (step) begin
            p   <= p_next;
         end
         if (capture)
            result <= mop == MUL_OP_UHI ? p_next[2*WORD-1:WORD] :
                      mop == MUL_OP_SHI ? hi_s : p_next[WORD-1:0];
      end
   end
endmodule

// File: rtl/ex_mul_ctrl.sv
// ex_mul_ctrl: EX-stage iterative multiply sequencer (FSM, counter, pipeline handshake)
module ex_mul_ctrl
   import ex_mul_ctrl_pkg::*;
#(
   parameter int WORD  = 64,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [WORD-1:0] result
);
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             accept, last;
   // The start-cycle term keeps the instruction in EX on the accepting edge
   assign accept = state == MUL_STATE_IDLE && start && !flush;
   assign last   = cnt == CNT_W'(WORD - 1);
   assign busy   = state == MUL_STATE_BUSY;
   assign done   = state == MUL_STATE_DONE;
   assign stall  = accept || busy;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MUL_STATE_IDLE;
         cnt   <= '0;
      end else begin
         state <= busy ? (flush ? MUL_STATE_IDLE : last ? MUL_STATE_DONE : MUL_STATE_BUSY) :
                  accept ? MUL_STATE_BUSY : MUL_STATE_IDLE;
         cnt   <= busy ? cnt + CNT_W'(1) : '0;
      end
   end
   ex_mul_dp #(.WORD(WORD)) u_dp (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (busy),
      .capture (busy && last && !flush),
      .op      (op),
      .a       (a),
      .b       (b),
      .result  (result)
   );
endmodule

// File: tb/tb_ex_mul_ctrl.sv
// tb_ex_mul_ctrl: directed-vector bench for the EX-stage multiply sequencer
module tb_ex_mul_ctrl;
   logic        tb_clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [63:0] a, b, result;
   logic        stall, busy, done;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;

   always #5 tb_clk = ~tb_clk;
   always @(posedge tb_clk) cyc <= cyc + 1;

   ex_mul_ctrl #(.WORD(64), .CNT_W(6)) dut (
      .clk    (tb_clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one start cycle (i=0) then observes 65 further cycles; done is expected at i=65
   task automatic run(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y, input bit hold,
                      output logic [63:0] res, output int n_stall, output int n_done,
                      output int done_at, output int done_cyc, output logic done_busy);
      n_stall = 0; n_done = 0; done_at = -1; done_cyc = -1; res = 'x; done_busy = 1'bx;
      @(negedge tb_clk);
      op = o; a = x; b = y; start = 1'b1;
      #1;
      if (stall) n_stall++;
      for (int i = 1; i <= 65; i++) begin
         @(negedge tb_clk);
         if (!hold) start = 1'b0;
         #1;
         if (stall) n_stall++;
         if (done) begin
            n_done++;
            if (done_at < 0) begin
               done_at = i; done_cyc = cyc; res = result; done_busy = busy;
            end
         end
      end
   endtask

   logic [63:0] r, r2;
   int ns, nd, da, dc, dc1;
   logic db;

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge tb_clk);
      #1;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", result, 64'd0);
      rst = 1'b0;

      run(2'b00, 64'd6, 64'd7, 1'b0, r, ns, nd, da, dc, db);
      check("mul6x7", r, 64'd42);
      check("mul6x7_stalls", 64'(ns), 64'd65);
      check("mul6x7_done_at", 64'(da), 64'd65);
      check("mul6x7_ndone", 64'(nd), 64'd1);
      check("mul6x7_busy_in_done", 64'(db), 64'd0);

      run(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, ns, nd, da, dc, db);
      check("umulh", r, 64'd1);
      run(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, ns, nd, da, dc, db);
      check("mul_lo_big", r, 64'hFFFF_FFFF_FFFF_FFFE);
      run(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, ns, nd, da, dc, db);
      check("op11_as_mul", r, 64'hFFFF_FFFF_FFFF_FFFE);
      run(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, ns, nd, da, dc, db);
      check("smulh_m1x2", r, 64'hFFFF_FFFF_FFFF_FFFF);
      run(2'b10, 64'h8000_0000_0000_0000, 64'd2, 1'b0, r, ns, nd, da, dc, db);
      check("smulh_min_x2", r, 64'hFFFF_FFFF_FFFF_FFFF);
      run(2'b10, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, r, ns, nd, da, dc, db);
      check("smulh_3xm5", r, 64'hFFFF_FFFF_FFFF_FFFF);

      @(negedge tb_clk);
      op = 2'b00; a = 64'd100; b = 64'd100; start = 1'b1;
      @(negedge tb_clk);
      start = 1'b0;
      repeat (9) @(negedge tb_clk);
      flush = 1'b1;
      @(negedge tb_clk);
      flush = 1'b0;
      #1;
      check("flush_stall", 64'(stall), 64'd0);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_result_kept", result, 64'hFFFF_FFFF_FFFF_FFFF);
      run(2'b00, 64'd3, 64'd5, 1'b0, r, ns, nd, da, dc, db);
      check("post_flush_mul", r, 64'd15);
      check("post_flush_stalls", 64'(ns), 64'd65);
      check("post_flush_done_at", 64'(da), 64'd65);
      check("post_flush_ndone", 64'(nd), 64'd1);

      run(2'b00, 64'd0, 64'h1234, 1'b0, r, ns, nd, da, dc, db);
      check("mul_zero", r, 64'd0);
      check("mul_zero_stalls", 64'(ns), 64'd65);

      run(2'b00, 64'd2, 64'd2, 1'b0, r, ns, nd, da, dc1, db);
      run(2'b00, 64'd3, 64'd3, 1'b0, r2, ns, nd, da, dc, db);
      check("b2b_first", r, 64'd4);
      check("b2b_second", r2, 64'd9);
      check("b2b_spacing", 64'(dc - dc1), 64'd66);

      run(2'b00, 64'd5, 64'd5, 1'b1, r, ns, nd, da, dc, db);
      check("hold_result", r, 64'd25);
      check("hold_ndone", 64'(nd), 64'd1);
      @(negedge tb_clk);
      #1;
      check("hold_idle_busy", 64'(busy), 64'd0);
      check("hold_idle_stall", 64'(stall), 64'd1);
      @(negedge tb_clk);
      #1;
      check("hold_restart_busy", 64'(busy), 64'd1);
      repeat (5) @(negedge tb_clk);
      rst = 1'b1; start = 1'b0;
      @(negedge tb_clk);
      #1;
      check("midrst_stall", 64'(stall), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_result", result, 64'd0);
      rst = 1'b0;

      @(negedge tb_clk);
      op = 2'b00; a = 64'd7; b = 64'd7; start = 1'b1; flush = 1'b1;
      #1;
      check("start_flush_stall", 64'(stall), 64'd0);
      @(negedge tb_clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("start_flush_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ex_mul_ctrl.md
# ex_mul_ctrl

Iterative multiply sequencer for the EX stage. When the ID/EX register holds a multiply-class instruction, this block takes the two register operands and runs a shift-add multiply over WORD cycles. While it runs, it holds the pipeline with `stall` and then presents a 64-bit result. It sits beside the EX ALU. Its `result` is muxed onto the ALU output path when `done` is high, and its `stall` output feeds the hazard unit.

## Interface
- `WORD`, default 64: operand and result width.
- `CNT_W`, default 6: iteration counter width; must equal log2(WORD).
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: multiply-class instruction is valid in EX.
- `op` input 2: `MUL_OP_LO` = 00 (MUL), `MUL_OP_UHI` = 01 (UMULH), `MUL_OP_SHI` = 10 (SMULH); 11 behaves as 00.
- `a` input WORD: r_data1 (Rn).
- `b` input WORD: r_data2 (Rm).
- `flush` input 1: branch taken or exception; abort the operation in flight.
- `stall` output 1: freeze PC, IF/ID and ID/EX.
- `busy` output 1: state is BUSY.
- `done` output 1: `result` is valid in this cycle.
- `result` output WORD: selected product half.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - BUSY: iterating.
  - DONE: result presented.
- IDLE -> BUSY on `start && !flush`. On that edge:
  - latch `a` (multiplicand), `op`, and the sign bits of `a` and `b`;
  - load the product register P[2*WORD-1:0] = {WORD'0, b};
  - cnt = 0.
- Each BUSY edge performs one iteration:
  - sum[WORD:0] = P_hi + (P[0] ? a : 0), keeping the carry bit;
  - P = {sum, P_lo} >> 1;
  - cnt++.
- BUSY -> DONE on the edge where cnt == WORD-1; that edge performs the final iteration.
- Result in DONE:
  - MUL: P_lo.
  - UMULH: P_hi.
  - SMULH: P_hi − (sign_a ? b_latched : 0) − (sign_b ? a_latched : 0), mod 2^WORD. `b` is latched too for this term.
  - The correction may be a registered step at the BUSY→DONE edge or combinational in DONE. `result` must be stable for the whole DONE cycle.
- DONE -> IDLE unconditionally on the next edge.
- `result` holds its last value in IDLE. It reads 0 after reset.
- `flush` in BUSY or DONE -> IDLE on the next edge:
  - no `done` pulse;
  - `result` is left unchanged from its previous value.
- `start` while BUSY or DONE is ignored. The pipeline is stalled in BUSY, so a new `start` is only legal from IDLE.
- `start && flush` in the same IDLE cycle: stay IDLE and do not assert `stall`.
- `rst` overrides everything, including mid-operation:
  - state = IDLE, P = 0, cnt = 0, `result` = 0;
  - all outputs read 0 on the cycle after the reset edge.

## Timing
- Let E0 be the edge where `start` is accepted.
- `stall` = (IDLE && `start` && !`flush`) || BUSY.
  - The combinational term for the start cycle is required so the instruction does not leave EX at E0.
- `busy` is high from E0 to E_WORD (WORD cycles).
- `done` is high exactly one cycle, from E_WORD to E_WORD+1. `stall` is low in that cycle, so EX/MEM captures `result` at E_WORD+1.
- Total `stall` = WORD+1 cycles per multiply: 65 cycles for WORD=64.
- Back-to-back: a new `start` can be accepted at E_WORD+2, its first IDLE cycle.
- Latency is fixed and data-independent; there is no early-out.
- Output values after reset: `stall` = 0, `busy` = 0, `done` = 0, `result` = 0.

## Structure
- `common.vh` gains `MUL_OP_LO`, `MUL_OP_UHI`, `MUL_OP_SHI`, `MUL_STATE_IDLE`, `MUL_STATE_BUSY` and `MUL_STATE_DONE`.
- A single sub-module, `ex_mul_dp`, is natural. It owns:
  - the P register;
  - the WORD+1 adder;
  - the latched operands;
  - the SMULH correction.
- `ex_mul_ctrl` owns the FSM, the counter and the handshake outputs.

## Test plan
- MUL, `a`=6, `b`=7, `start` one cycle -> `stall` high 65 cycles; `done` high in cycle 65 only; `result` = 42; `busy` low in that cycle.
- UMULH, `a`=64'hFFFF_FFFF_FFFF_FFFF, `b`=2 -> `result` = 1. MUL with the same operands -> 64'hFFFF_FFFF_FFFF_FFFE.
- SMULH, `a`=−1, `b`=2 -> `result` = 64'hFFFF_FFFF_FFFF_FFFF. SMULH, `a`=64'h8000_0000_0000_0000, `b`=2 -> 64'hFFFF_FFFF_FFFF_FFFF.
- `flush` asserted 10 cycles after E0 -> IDLE next edge; `stall` and `busy` drop; no `done`; `result` keeps its prior value. A new MUL 3×5 started in the following cycle gives `result` 15 with full latency.
- `rst` pulsed mid-BUSY -> all outputs 0 the next cycle. `start` held high through BUSY -> exactly one `done`; a second operation starts only once IDLE is reached.
- MUL, `a`=0, `b`=64'h1234 -> `result` = 0, still 65 stall cycles. Back-to-back MULs 2×2 and 3×3 -> `done` pulses spaced 66 cycles apart, `result` 4 then 9.
